// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file with pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef logic [XLEN_DEF-1:0]          xlen_t;
  typedef logic [$clog2(NREGS_DEF)-1:0] regaddr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at commit or flush.
// Register x0 is never marked.
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  output logic [NREGS-1:0] pend
);

  logic [NREGS-1:0] pend_q, pend_d;

  // Flush kills everything; a same-cycle issue beats a commit since it is the newer writer.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREGS; r++) begin
      if (flush) begin
        pend_d[r] = 1'b0;
      end else if (iss_valid && (iss_rd == AW'(r))) begin
        pend_d[r] = 1'b1;
      end else if (wr_en && (wr_addr == AW'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one write port and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle commit to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREGS-1:0]    sb_busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend;

  // regs_q[0] is only ever cleared, so it stays zero after the first reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .pend      (pend)
  );

  assign sb_busy_vec = pend;

  for (genvar k = 0; k < NRD; k++) begin : g_rd_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      data = (addr == '0) ? '0 : regs_q[addr];
      busy = pend[addr];
`ifdef REGFILE_BYPASS_EN
      // Forwarded commit clears busy unless a newer writer issues to the same register now.
      if (wr_en && (wr_addr == addr) && (wr_addr != '0)) begin
        data = wr_data;
        busy = iss_valid && (iss_rd == wr_addr) && !flush;
      end
`endif
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = busy;
  end

endmodule
